// File: rtl/q100_fetch_pkg.sv
// Shared types, widths and opcode constants for the q100 IF stage.
package q100_fetch_pkg;

  localparam int unsigned LEN_REG_VAL = 32;
  localparam int unsigned LEN_INSTR   = 32;
  localparam int unsigned LEN_RS1     = 5;
  localparam int unsigned LEN_RS2     = 5;
  localparam int unsigned LEN_RD      = 5;
  localparam int unsigned LEN_FUNCT3  = 3;
  localparam int unsigned LEN_FUNCT7  = 7;
  localparam int unsigned LEN_OPCODE  = 7;
  localparam int unsigned LEN_IMM     = 32;

  localparam logic [LEN_OPCODE-1:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [LEN_OPCODE-1:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [LEN_OPCODE-1:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [LEN_OPCODE-1:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [LEN_OPCODE-1:0] OPCODE_OP     = 7'b0110011;
  localparam logic [LEN_OPCODE-1:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [LEN_OPCODE-1:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [LEN_OPCODE-1:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [LEN_OPCODE-1:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [LEN_OPCODE-1:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_e;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R} imm_fmt_e;

  // Decoded fields presented to decode, registered as one unit.
  typedef struct packed {
    logic [LEN_FUNCT7-1:0] funct7;
    logic [LEN_RS2-1:0]    rs2;
    logic [LEN_RS1-1:0]    rs1;
    logic [LEN_FUNCT3-1:0] funct3;
    logic [LEN_RD-1:0]     rd;
    logic [LEN_OPCODE-1:0] opcode;
    logic [LEN_IMM-1:0]    imm;
  } fetch_fields_t;

  // Immediate format selected by opcode; anything unrecognised carries no immediate.
  function automatic imm_fmt_e imm_fmt_of(input logic [LEN_OPCODE-1:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR, OPCODE_SYSTEM: fmt = FMT_I;
      OPCODE_STORE:                                          fmt = FMT_S;
      OPCODE_BRANCH:                                         fmt = FMT_B;
      OPCODE_LUI, OPCODE_AUIPC:                              fmt = FMT_U;
      OPCODE_JAL:                                            fmt = FMT_J;
      default:                                               fmt = FMT_R;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/q100_fetch_if.sv
// Instruction-memory req/ack port between fetch (master) and imem (slave).
interface q100_fetch_if;
  import q100_fetch_pkg::*;

  logic                   req;
  logic [LEN_REG_VAL-1:0] addr;
  logic                   ack;
  logic [LEN_INSTR-1:0]   rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/q100_imm_gen.sv
// Combinational RV32I immediate extraction; reusable by decode.
module q100_imm_gen
  import q100_fetch_pkg::*;
(
  input  logic [LEN_INSTR-1:0] i_instr,
  output logic [LEN_IMM-1:0]   o_imm_c
);

  // Select and sign-extend the immediate according to the opcode's format.
  always_comb begin
    o_imm_c = '0;
    case (imm_fmt_of(i_instr[6:0]))
      FMT_I:   o_imm_c = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   o_imm_c = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   o_imm_c = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U:   o_imm_c = {i_instr[31:12], 12'b0};
      FMT_J:   o_imm_c = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm_c = '0;
    endcase
  end

endmodule

// File: rtl/q100_fetch.sv
// IF stage: drives the PC, fetches over req/ack, splits words into fields.
module q100_fetch
  import q100_fetch_pkg::*;
#(
  parameter logic [LEN_REG_VAL-1:0] RESET_PC = '0,
  parameter int unsigned            PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  q100_fetch_if.master           imem,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [LEN_REG_VAL-1:0] redirect_pc_i,
  output logic [LEN_REG_VAL-1:0] pc_o,
  output logic                   keep_o,
  output logic [LEN_RS1-1:0]     rs1_o,
  output logic [LEN_RS2-1:0]     rs2_o,
  output logic [LEN_RD-1:0]      rd_o,
  output logic [LEN_FUNCT3-1:0]  funct3_o,
  output logic [LEN_FUNCT7-1:0]  funct7_o,
  output logic [LEN_OPCODE-1:0]  opcode_o,
  output logic [LEN_IMM-1:0]     imm_o
);

  localparam logic [LEN_REG_VAL-1:0] STEP = LEN_REG_VAL'(PC_STEP);

  fetch_state_e           r_state;
  logic                   r_req;
  logic [LEN_REG_VAL-1:0] r_addr;
  logic [LEN_REG_VAL-1:0] r_pc;
  logic                   r_drop;
  logic                   r_skid_vld;
  logic [LEN_INSTR-1:0]   r_skid_word;
  logic [LEN_REG_VAL-1:0] r_skid_pc;
  logic                   r_keep;
  logic [LEN_REG_VAL-1:0] r_out_pc;
  fetch_fields_t          r_fields;

  logic [LEN_INSTR-1:0]   w_word;
  logic [LEN_REG_VAL-1:0] w_word_pc;
  logic [LEN_IMM-1:0]     w_imm;
  fetch_fields_t          w_fields;

  // The presented word comes from the skid while it holds one, else straight from imem.
  always_comb begin
    w_word    = r_skid_vld ? r_skid_word : imem.rdata;
    w_word_pc = r_skid_vld ? r_skid_pc   : r_addr;
  end

  q100_imm_gen u_imm_gen (
    .i_instr (w_word),
    .o_imm_c (w_imm)
  );

  // Split the selected word into decode fields.
  always_comb begin
    w_fields        = '0;
    w_fields.funct7 = w_word[31:25];
    w_fields.rs2    = w_word[24:20];
    w_fields.rs1    = w_word[19:15];
    w_fields.funct3 = w_word[14:12];
    w_fields.rd     = w_word[11:7];
    w_fields.opcode = w_word[6:0];
    w_fields.imm    = w_imm;
  end

  // Fetch FSM, skid buffer, drop flag and registered ID-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_word <= '0;
      r_skid_pc   <= '0;
      r_keep      <= 1'b1;
      r_out_pc    <= '0;
      r_fields    <= '0;
    end else if (redirect_i) begin
      // Redirect beats ack and stall: flush skid, emit a bubble, retarget.
      r_state    <= FETCH;
      r_pc       <= redirect_pc_i;
      r_skid_vld <= 1'b0;
      r_keep     <= 1'b1;
      r_out_pc   <= '0;
      r_fields   <= '0;
      if (r_req && !imem.ack) begin
        // Outstanding request: keep req/addr stable and discard its word later.
        r_drop <= 1'b1;
      end else begin
        r_drop <= 1'b0;
        r_req  <= 1'b1;
        r_addr <= redirect_pc_i;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        FETCH: begin
          if (r_drop) begin
            if (imem.ack) begin
              r_drop <= 1'b0;
              r_addr <= r_pc;
            end
            if (!stall_i) begin
              r_keep   <= 1'b1;
              r_out_pc <= '0;
              r_fields <= '0;
            end
          end else if (imem.ack) begin
            r_pc   <= r_pc + STEP;
            r_addr <= r_pc + STEP;
            if (!stall_i) begin
              r_keep   <= 1'b0;
              r_out_pc <= w_word_pc;
              r_fields <= w_fields;
            end else begin
              r_skid_vld  <= 1'b1;
              r_skid_word <= imem.rdata;
              r_skid_pc   <= r_addr;
              r_req       <= 1'b0;
              r_state     <= HOLD;
            end
          end else if (!stall_i) begin
            r_keep   <= 1'b1;
            r_out_pc <= '0;
            r_fields <= '0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            r_keep     <= 1'b0;
            r_out_pc   <= w_word_pc;
            r_fields   <= w_fields;
            r_skid_vld <= 1'b0;
            r_req      <= 1'b1;
            r_addr     <= r_pc;
            r_state    <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req  = r_req;
  assign imem.addr = r_addr;

  assign pc_o     = r_out_pc;
  assign keep_o   = r_keep;
  assign rs1_o    = r_fields.rs1;
  assign rs2_o    = r_fields.rs2;
  assign rd_o     = r_fields.rd;
  assign funct3_o = r_fields.funct3;
  assign funct7_o = r_fields.funct7;
  assign opcode_o = r_fields.opcode;
  assign imm_o    = r_fields.imm;

endmodule

// File: tb/tb_q100_fetch.sv
// Directed and randomized checks of q100_fetch against a transaction-level model.
module tb_q100_fetch;
  import q100_fetch_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   stall_i;
  logic                   redirect_i;
  logic [LEN_REG_VAL-1:0] redirect_pc_i;
  logic [LEN_REG_VAL-1:0] pc_o;
  logic                   keep_o;
  logic [LEN_RS1-1:0]     rs1_o;
  logic [LEN_RS2-1:0]     rs2_o;
  logic [LEN_RD-1:0]      rd_o;
  logic [LEN_FUNCT3-1:0]  funct3_o;
  logic [LEN_FUNCT7-1:0]  funct7_o;
  logic [LEN_OPCODE-1:0]  opcode_o;
  logic [LEN_IMM-1:0]     imm_o;

  q100_fetch_if imem ();

  q100_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem.master),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .keep_o        (keep_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .funct3_o      (funct3_o),
    .funct7_o      (funct7_o),
    .opcode_o      (opcode_o),
    .imm_o         (imm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] W_ADDI5   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] W_LUI     = 32'h1234_5137; // lui x2,0x12345
  localparam logic [31:0] W_ADDIM1  = 32'hFFF0_0193; // addi x3,x0,-1
  localparam logic [31:0] W_ADD     = 32'h0073_02B3; // add x5,x6,x7
  localparam logic [31:0] W_BEQ_M4  = 32'hFE00_0EE3; // beq x0,x0,-4
  localparam logic [31:0] W_SW_M8   = 32'hFE00_2C23; // sw x0,-8(x0)
  localparam logic [31:0] W_JAL_2K  = 32'h0010_006F; // jal x0,+2048

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] mem [64];
  logic [6:0]  ops [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Immediate as the RV32I formats define it, chosen by opcode.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: return {{20{w[31]}}, w[31:20]};
      7'h23:                      return {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:                      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17:               return {w[31:12], 12'h000};
      7'h6F:                      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:                    return 32'h0;
    endcase
  endfunction

  task automatic chk_word(input string tag, input logic [31:0] w, input logic [31:0] pc);
    chk({tag, "_keep"},   32'(keep_o),   32'h0);
    chk({tag, "_pc"},     pc_o,          pc);
    chk({tag, "_rs1"},    32'(rs1_o),    32'(w[19:15]));
    chk({tag, "_rs2"},    32'(rs2_o),    32'(w[24:20]));
    chk({tag, "_rd"},     32'(rd_o),     32'(w[11:7]));
    chk({tag, "_funct3"}, 32'(funct3_o), 32'(w[14:12]));
    chk({tag, "_funct7"}, 32'(funct7_o), 32'(w[31:25]));
    chk({tag, "_opcode"}, 32'(opcode_o), 32'(w[6:0]));
    chk({tag, "_imm"},    imm_o,         ref_imm(w));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_keep"},   32'(keep_o),   32'h1);
    chk({tag, "_rd"},     32'(rd_o),     32'h0);
    chk({tag, "_opcode"}, 32'(opcode_o), 32'h0);
    chk({tag, "_imm"},    imm_o,         32'h0);
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(imem.req), 32'(req));
    if (req) chk({tag, "_addr"}, imem.addr, addr);
  endtask

  // Model state for the randomized phase.
  logic [31:0] m_fetch_pc;
  logic        m_skid_vld;
  logic [31:0] m_skid_word;
  logic [31:0] m_skid_pc;
  logic        m_keep;
  logic [31:0] m_word;
  logic [31:0] m_pc;
  logic [31:0] r;

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem.ack = 1'b0; imem.rdata = '0;

    // Reset values
    step(); step();
    chk("rst_req",  32'(imem.req), 32'h0);
    chk("rst_addr", imem.addr,     32'h0);
    chk("rst_pc",   pc_o,          32'h0);
    chk_bubble("rst");

    // 1: release, back-to-back acks
    rst = 1'b0;
    step();
    chk_bus("t1_first", 1'b1, 32'h0);
    chk_bubble("t1_idle");
    imem.ack = 1'b1; imem.rdata = W_ADDI5;
    step();
    chk_word("t1_addi", W_ADDI5, 32'h0);
    chk("t1_addi_imm5", imm_o, 32'h5);
    chk_bus("t1_a4", 1'b1, 32'h4);
    imem.rdata = W_LUI;
    step();
    chk_word("t1_lui", W_LUI, 32'h4);
    chk("t1_lui_imm", imm_o, 32'h1234_5000);
    chk_bus("t1_a8", 1'b1, 32'h8);

    // 2: ack delayed three cycles
    imem.ack = 1'b0; imem.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bubble("t2_wait");
      chk_bus("t2_wait", 1'b1, 32'h8);
    end
    imem.ack = 1'b1; imem.rdata = W_ADDIM1;
    step();
    chk_word("t2_word", W_ADDIM1, 32'h8);
    chk_bus("t2_next", 1'b1, 32'hC);

    // 3: stall in the ack cycle, held two cycles
    stall_i = 1'b1; imem.rdata = W_ADD;
    step();
    chk_word("t3_frz1", W_ADDIM1, 32'h8);
    chk_bus("t3_frz1", 1'b0, 32'h0);
    imem.ack = 1'b0; imem.rdata = 32'h0;
    step();
    chk_word("t3_frz2", W_ADDIM1, 32'h8);
    chk_bus("t3_frz2", 1'b0, 32'h0);
    stall_i = 1'b0;
    step();
    chk_word("t3_drain", W_ADD, 32'hC);
    chk_bus("t3_next", 1'b1, 32'h10);

    // 4: redirect with a request outstanding, then re-redirect while dropping
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step();
    chk_bubble("t4_r1");
    chk_bus("t4_r1", 1'b1, 32'h10);
    redirect_pc_i = 32'h100;
    step();
    chk_bubble("t4_r2");
    chk_bus("t4_r2", 1'b1, 32'h10);
    redirect_i = 1'b0;
    imem.ack = 1'b1; imem.rdata = W_ADDI5;
    step();
    chk_bubble("t4_drop");
    chk_bus("t4_new", 1'b1, 32'h100);

    // 5: immediate formats
    imem.rdata = W_BEQ_M4;
    step();
    chk_word("t5_beq", W_BEQ_M4, 32'h100);
    chk("t5_beq_imm", imm_o, 32'hFFFF_FFFC);
    imem.rdata = W_SW_M8;
    step();
    chk_word("t5_sw", W_SW_M8, 32'h104);
    chk("t5_sw_imm", imm_o, 32'hFFFF_FFF8);
    imem.rdata = W_JAL_2K;
    step();
    chk_word("t5_jal", W_JAL_2K, 32'h108);
    chk("t5_jal_imm", imm_o, 32'h0000_0800);

    // 6: reset mid-fetch, late ack ignored
    imem.ack = 1'b0; rst = 1'b1;
    step();
    chk_bubble("t6_rst");
    chk("t6_rst_req", 32'(imem.req), 32'h0);
    chk("t6_rst_pc",  pc_o,          32'h0);
    rst = 1'b0; imem.ack = 1'b1; imem.rdata = W_LUI;
    step();
    chk_bubble("t6_late");
    chk_bus("t6_restart", 1'b1, 32'h0);

    // Redirect with ack in the same cycle, then PC wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; imem.rdata = W_ADDI5;
    step();
    chk_bubble("t7_redir_ack");
    chk_bus("t7_redir_ack", 1'b1, 32'hFFFF_FFFC);
    redirect_i = 1'b0; imem.rdata = W_LUI;
    step();
    chk_word("t7_top", W_LUI, 32'hFFFF_FFFC);
    chk_bus("t7_wrap", 1'b1, 32'h0);
    imem.ack = 1'b0;

    // Randomized phase: random ack gaps and stalls against the model
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      mem[i] = {r[31:7], ops[$urandom_range(0, 11)]};
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    m_fetch_pc = 32'h0; m_skid_vld = 1'b0; m_skid_word = '0; m_skid_pc = '0;
    m_keep = 1'b1; m_word = '0; m_pc = '0;
    for (int c = 0; c < 300; c++) begin
      chk_bus("rnd_bus", !m_skid_vld, m_fetch_pc);
      r = $urandom;
      stall_i    = (r[1:0] == 2'b00);
      imem.ack   = imem.req && (r[3:2] != 2'b00);
      imem.rdata = mem[imem.addr[7:2]];
      if (m_skid_vld) begin
        if (!stall_i) begin
          m_keep = 1'b0; m_word = m_skid_word; m_pc = m_skid_pc; m_skid_vld = 1'b0;
        end
      end else if (imem.ack) begin
        if (!stall_i) begin
          m_keep = 1'b0; m_word = mem[m_fetch_pc[7:2]]; m_pc = m_fetch_pc;
        end else begin
          m_skid_vld = 1'b1; m_skid_word = mem[m_fetch_pc[7:2]]; m_skid_pc = m_fetch_pc;
        end
        m_fetch_pc = m_fetch_pc + 32'd4;
      end else if (!stall_i) begin
        m_keep = 1'b1;
      end
      step();
      if (m_keep) chk_bubble("rnd_bub");
      else        chk_word("rnd_word", m_word, m_pc);
    end
    imem.ack = 1'b0; stall_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
